ov5640_reg_sequencer: RTL and testbench
=======================================

// Module: ov5640_reg_sequencer
// PURPOSE
//  Walks an OV5640 init table of {cmd, reg_addr16, data8} entries, issuing each write to the SCCB byte engine.
//  Started by the power-up sequencer once reset release and the 21 ms settle have completed.
//  Handles ms delays, NACK retry, timeout and END, then reports done/error to start-up logic.
//  The table lives in sub-module ov5640_init_rom, which has one-cycle read latency.
// PARAMETERS
//  CLK_HZ      25_000_000  meg25 frequency; ms tick = CLK_HZ/1000 cycles
//  ROM_AW      8           table address width; depth = 2**ROM_AW
//  MAX_RETRY   3           re-issues after NACK/timeout before ERROR (0 = no retry)
//  TIMEOUT_CYC 2_000_000   cycles waiting for sccb_done before counting a failure (80 ms)
// PORTS
//  meg25       in  1   system clock (25 MHz)
//  rst         in  1   asynchronous reset, active-high
//  start       in  1   1-cycle pulse; begins the sequence from index 0
//  busy        out 1   high from accepted start until DONE/ERROR
//  done        out 1   level; table completed without error
//  error       out 1   level; retries exhausted or bad cmd
//  err_index   out ROM_AW index of failing entry (valid when error=1)
//  sccb_req    out 1   1-cycle request pulse to SCCB engine
//  sccb_rw     out 1   0=write, 1=read
//  sccb_addr   out 16  OV5640 register address
//  sccb_wdata  out 8   write data
//  sccb_rdata  in  8   read data, valid with sccb_done
//  sccb_done   in  1   1-cycle completion pulse from SCCB engine
//  sccb_nack   in  1   qualifies sccb_done: slave did not ACK
// BEHAVIOUR
//  Async reset: all outputs 0, state IDLE, index 0, retry/timer counters 0. In-flight SCCB transaction is abandoned.
//  Entry format, 26 bits: [25:24] cmd, [23:8] addr, [7:0] data.
//  cmd encodings: 00 WRITE, 01 DELAY (data = ms; 0 = no wait), 10 END, 11 illegal -> ERROR.
//  FSM transitions:
//    IDLE -start-> FETCH.
//    FETCH: drive rom_addr=index; 1 cycle -> DECODE.
//    DECODE: branch on cmd.
//    WR_REQ: sccb_req=1 for exactly 1 cycle; addr/wdata/rw held stable until sccb_done -> WR_WAIT.
//    WR_WAIT: done & !nack -> NEXT. done & nack, or timer==TIMEOUT_CYC -> retry++; retry<=MAX_RETRY ? WR_REQ : ERROR.
//    DELAY: count data*CLK_HZ/1000 cycles -> NEXT.
//    NEXT: retry=0; index==2**ROM_AW-1 ? DONE (implicit END, no wrap) : index+1 -> FETCH.
//    END -> DONE.
//  Latency: start to first sccb_req = 3 cycles (FETCH, DECODE, WR_REQ).
//  start is ignored while busy. start in DONE/ERROR clears done/error/err_index and restarts from index 0.
//  sccb_done outside WR_WAIT/RD_WAIT is ignored. done and nack in the timeout cycle count as a nack; one failure only.
//  error and done are never high together; busy=0 in IDLE/DONE/ERROR.
// CONFIGURATION
//  Macro OV5640_READBACK_VERIFY_EN:
//    Defined: after a successful WRITE, go RD_REQ/RD_WAIT with sccb_rw=1, same addr, same retry/timeout rules.
//    rdata != written data -> ERROR with err_index = that entry.
//    Registers 0x3008 and 0x3103 are excluded from verify.
//    Not defined: RD states absent; sccb_rw tied 0; sccb_rdata unused.
// STRUCTURE
//  ov5640_pkg: cmd encodings, state encodings, entry field offsets, MS_CYC = CLK_HZ/1000.
//  ov5640_init_rom (sub-module): registered ROM, ROM_AW in, 26-bit entry out. Contents come from the team's init-table file.
//  Top contains the FSM, index counter, retry counter and shared delay/timeout timer (ceil log2 of max(255*MS_CYC, TIMEOUT_CYC) bits).
// TESTING
//  3-entry ROM {W 0x3008=0x82, D 5, END}, start:
//    sccb_req with addr 0x3008, wdata 0x82 at cycle 3; the bench model returns done@+10.
//    Next FETCH arrives 125000 cycles after NEXT; done=1, busy=0.
//  NACK twice then ACK on entry 0, MAX_RETRY=3: three sccb_req pulses, then done=1 and error=0.
//  NACK four times: error=1, err_index=0, busy=0, no fifth req.
//  sccb_done never arrives: after TIMEOUT_CYC, req re-issues. Final ERROR after 4*TIMEOUT_CYC + overhead.
//  rst asserted during DELAY, then start: outputs are 0 immediately and the sequence restarts at index 0.
//  ROM with illegal cmd 11 at index 2: error=1, err_index=2. A start pulse in ERROR clears error and reruns the table.

Source files
------------

// File: rtl/ov5640_reg_sequencer_pkg.sv
// Shared encodings, entry layout and table helpers for the OV5640 register sequencer.
// Entry layout: [25:24] cmd, [23:8] register address, [7:0] data.
package ov5640_reg_sequencer_pkg;

    localparam int ENTRY_W   = 26;
    localparam int CMD_LSB   = 24;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_LSB  = 0;
    localparam int TABLE_MAX = 256;
    localparam int TABLE_W   = ENTRY_W * TABLE_MAX;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_DELAY = 2'b01,
        CMD_END   = 2'b10,
        CMD_BAD   = 2'b11
    } cmd_e;

    typedef struct packed {
        cmd_e        cmd;
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR_REQ,
        S_WR_WAIT,
`ifdef OV5640_READBACK_VERIFY_EN
        S_RD_REQ,
        S_RD_WAIT,
`endif
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_e;

    function automatic int unsigned ms_cyc(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic logic [ENTRY_W-1:0] mk_entry(input cmd_e cmd, input logic [15:0] addr,
                                                    input logic [7:0] data);
        logic [ENTRY_W-1:0] e;
        e                     = '0;
        e[CMD_LSB +: 2]       = cmd;
        e[ADDR_LSB +: 16]     = addr;
        e[DATA_LSB +: 8]      = data;
        return e;
    endfunction

    // Software reset and clock-source select do not read back what was written.
    function automatic logic verify_excluded(input logic [15:0] addr);
        return (addr == 16'h3008) || (addr == 16'h3103);
    endfunction

    function automatic logic [TABLE_W-1:0] default_table();
        logic [TABLE_W-1:0] t;
        for (int i = 0; i < TABLE_MAX; i++) t[i*ENTRY_W +: ENTRY_W] = mk_entry(CMD_END, 16'h0, 8'h0);
        t[0*ENTRY_W +: ENTRY_W] = mk_entry(CMD_WRITE, 16'h3103, 8'h11);
        t[1*ENTRY_W +: ENTRY_W] = mk_entry(CMD_WRITE, 16'h3008, 8'h82);
        t[2*ENTRY_W +: ENTRY_W] = mk_entry(CMD_DELAY, 16'h0000, 8'd5);
        t[3*ENTRY_W +: ENTRY_W] = mk_entry(CMD_WRITE, 16'h3008, 8'h42);
        t[4*ENTRY_W +: ENTRY_W] = mk_entry(CMD_WRITE, 16'h3103, 8'h03);
        t[5*ENTRY_W +: ENTRY_W] = mk_entry(CMD_WRITE, 16'h3017, 8'hff);
        t[6*ENTRY_W +: ENTRY_W] = mk_entry(CMD_WRITE, 16'h3018, 8'hff);
        return t;
    endfunction

endpackage

// File: rtl/ov5640_reg_sequencer_if.sv
// Request/completion bus between the register sequencer (master) and the SCCB byte engine (slave).
interface ov5640_reg_sequencer_if;
    logic        req;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        done;
    logic        nack;

    modport master (output req, rw, addr, wdata, input rdata, done, nack);
    modport slave  (input req, rw, addr, wdata, output rdata, done, nack);
endinterface

// File: rtl/ov5640_init_rom.sv
// Registered init-table ROM: entry for addr appears one cycle after addr is presented.
module ov5640_init_rom
    import ov5640_reg_sequencer_pkg::*;
#(
    parameter int unsigned         ROM_AW   = 8,
    parameter logic [TABLE_W-1:0]  ROM_INIT = default_table()
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] addr,
    output entry_t            data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data <= '0;
        else     data <= ROM_INIT[int'(addr)*ENTRY_W +: ENTRY_W];
    end

endmodule

// File: rtl/ov5640_reg_sequencer.sv
// Walks the init table issuing SCCB writes with ms delays, NACK/timeout retry; start to first req = 3 cycles.
// One outstanding SCCB request held stable until sccb.done; OV5640_READBACK_VERIFY_EN adds read-back compare.
module ov5640_reg_sequencer
    import ov5640_reg_sequencer_pkg::*;
#(
    parameter int unsigned        CLK_HZ      = 25_000_000,
    parameter int unsigned        ROM_AW      = 8,
    parameter int unsigned        MAX_RETRY   = 3,
    parameter int unsigned        TIMEOUT_CYC = 2_000_000,
    parameter logic [TABLE_W-1:0] ROM_INIT    = default_table()
) (
    input  logic                          meg25,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [ROM_AW-1:0]             err_index,
    ov5640_reg_sequencer_if.master        sccb
);

    localparam int unsigned MS_CYC  = ms_cyc(CLK_HZ);
    localparam int unsigned DLY_MAX = 255 * MS_CYC;
    localparam int unsigned TMAX    = (DLY_MAX > TIMEOUT_CYC) ? DLY_MAX : TIMEOUT_CYC;
    localparam int          TW      = $clog2(TMAX + 1);
    localparam int          RW      = $clog2(MAX_RETRY + 2);
    localparam logic [ROM_AW-1:0] LAST_INDEX = '1;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ROM_AW-1:0] err_index_q, err_index_d;
    entry_t            rom_q;
    logic              in_wait, xfer_ok, xfer_fail;

    ov5640_init_rom #(
        .ROM_AW   (ROM_AW),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk  (meg25),
        .rst  (rst),
        .addr (index_q),
        .data (rom_q)
    );

    always_comb begin
        in_wait = (state_q == S_WR_WAIT);
`ifdef OV5640_READBACK_VERIFY_EN
        if (state_q == S_RD_WAIT) in_wait = 1'b1;
`endif
    end

    // A NACK that lands on the timeout cycle is one failure, not two.
    assign xfer_ok   = in_wait && sccb.done && !sccb.nack;
    assign xfer_fail = in_wait && !xfer_ok && (sccb.done || (timer_q == TW'(TIMEOUT_CYC)));

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_index_d = err_index_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (rom_q.cmd)
                    CMD_WRITE: begin
                        addr_d  = rom_q.addr;
                        wdata_d = rom_q.data;
                        retry_d = '0;
                        state_d = S_WR_REQ;
                    end
                    CMD_DELAY: begin
                        timer_d = TW'(32'(rom_q.data) * MS_CYC);
                        state_d = (rom_q.data == 8'd0) ? S_NEXT : S_DELAY;
                    end
                    CMD_END:   state_d = S_DONE;
                    default: begin
                        err_index_d = index_q;
                        state_d     = S_ERROR;
                    end
                endcase
            end
            S_WR_REQ: begin
                timer_d = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (xfer_ok) begin
                    retry_d = '0;
`ifdef OV5640_READBACK_VERIFY_EN
                    state_d = verify_excluded(addr_q) ? S_NEXT : S_RD_REQ;
`else
                    state_d = S_NEXT;
`endif
                end
            end
`ifdef OV5640_READBACK_VERIFY_EN
            S_RD_REQ: begin
                timer_d = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (xfer_ok) begin
                    if (sccb.rdata == wdata_q) begin
                        retry_d = '0;
                        state_d = S_NEXT;
                    end else begin
                        err_index_d = index_q;
                        state_d     = S_ERROR;
                    end
                end
            end
`endif
            S_DELAY: begin
                timer_d = timer_q - TW'(1);
                if (timer_q <= TW'(1)) state_d = S_NEXT;
            end
            S_NEXT: begin
                retry_d = '0;
                if (index_q == LAST_INDEX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + ROM_AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    index_d     = '0;
                    retry_d     = '0;
                    err_index_d = '0;
                    state_d     = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer_fail) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = S_WR_REQ;
`ifdef OV5640_READBACK_VERIFY_EN
                if (state_q == S_RD_WAIT) state_d = S_RD_REQ;
`endif
            end else begin
                err_index_d = index_q;
                state_d     = S_ERROR;
            end
        end
    end

    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_index_q <= err_index_d;
        end
    end

    assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign err_index = err_index_q;

    assign sccb.addr  = addr_q;
    assign sccb.wdata = wdata_q;
`ifdef OV5640_READBACK_VERIFY_EN
    assign sccb.req = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign sccb.rw  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
`else
    assign sccb.req = (state_q == S_WR_REQ);
    assign sccb.rw  = 1'b0;
    logic unused_rdata;
    assign unused_rdata = ^sccb.rdata;
`endif

endmodule

// File: tb/tb_ov5640_reg_sequencer.sv
// Bench for ov5640_reg_sequencer: a main-table instance and an illegal-command-table instance,
// each answered by a behavioural SCCB engine.
module tb_ov5640_reg_sequencer;
    import ov5640_reg_sequencer_pkg::*;

    localparam int unsigned CLK_HZ = 25_000;   // 25 cycles per ms keeps delays short
    localparam int unsigned TO     = 300;
    localparam int unsigned ROM_AW = 2;

    function automatic logic [TABLE_W-1:0] fill(input logic [ENTRY_W-1:0] e0, e1, e2);
        logic [TABLE_W-1:0] t;
        for (int i = 0; i < TABLE_MAX; i++) t[i*ENTRY_W +: ENTRY_W] = mk_entry(CMD_END, 16'h0, 8'h0);
        t[0 +: ENTRY_W]         = e0;
        t[ENTRY_W +: ENTRY_W]   = e1;
        t[2*ENTRY_W +: ENTRY_W] = e2;
        return t;
    endfunction

    localparam logic [TABLE_W-1:0] TBL_MAIN = fill(mk_entry(CMD_WRITE, 16'h3008, 8'h82),
                                                   mk_entry(CMD_DELAY, 16'h0000, 8'd5),
                                                   mk_entry(CMD_END,   16'h0000, 8'h00));
    localparam logic [TABLE_W-1:0] TBL_BAD  = fill(mk_entry(CMD_WRITE, 16'h3103, 8'h11),
                                                   mk_entry(CMD_DELAY, 16'h0000, 8'd0),
                                                   mk_entry(CMD_BAD,   16'h1234, 8'h56));

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    logic              meg25 = 1'b0;
    logic              rst, start, start2;
    logic              busy, done, error, busy2, done2, error2;
    logic [ROM_AW-1:0] err_index, err_index2;

    ov5640_reg_sequencer_if sif ();
    ov5640_reg_sequencer_if sif2 ();

    ov5640_reg_sequencer #(.CLK_HZ(CLK_HZ), .ROM_AW(ROM_AW), .MAX_RETRY(3), .TIMEOUT_CYC(TO),
                           .ROM_INIT(TBL_MAIN)) u_dut (
        .meg25(meg25), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .err_index(err_index), .sccb(sif));

    ov5640_reg_sequencer #(.CLK_HZ(CLK_HZ), .ROM_AW(ROM_AW), .MAX_RETRY(3), .TIMEOUT_CYC(TO),
                           .ROM_INIT(TBL_BAD)) u_dut_bad (
        .meg25(meg25), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .error(error2), .err_index(err_index2), .sccb(sif2));

    always #5 meg25 = ~meg25;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t exp_q[$], exp2_q[$];
    exp_t e, e2;
    int   nreq, first_req, last_req, prev_req, resp_cyc, resp_at, nreq2, resp2_at;
    int   nack_left = 0;
    bit   mute = 0, pend = 0, pend2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge meg25) cyc <= cyc + 1;

    // SCCB engine for the main instance: completes 10 cycles after each request.
    always @(negedge meg25) begin
        sif.done = 1'b0;
        sif.nack = 1'b0;
        if (pend && cyc == resp_at) begin
            pend = 0;
            if (!mute) begin
                sif.done = 1'b1;
                sif.nack = (nack_left > 0);
                if (nack_left > 0) nack_left--;
                resp_cyc = cyc;
            end
        end
        if (sif.req) begin
            nreq++;
            if (nreq == 1) first_req = cyc;
            prev_req = last_req;
            last_req = cyc;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_addr", sif.addr, e.addr);
                check("req_wdata", sif.wdata, e.wdata);
                check("req_rw", sif.rw, 0);
            end
            pend      = 1;
            resp_at   = cyc + 10;
            sif.rdata = sif.wdata;
        end
    end

    always @(negedge meg25) begin
        sif2.done = 1'b0;
        sif2.nack = 1'b0;
        if (pend2 && cyc == resp2_at) begin
            pend2     = 0;
            sif2.done = 1'b1;
        end
        if (sif2.req) begin
            nreq2++;
            if (exp2_q.size() > 0) begin
                e2 = exp2_q.pop_front();
                check("req2_addr", sif2.addr, e2.addr);
                check("req2_wdata", sif2.wdata, e2.wdata);
            end
            pend2      = 1;
            resp2_at   = cyc + 2;
            sif2.rdata = sif2.wdata;
        end
    end

    task automatic pulse_start(output int at);
        @(negedge meg25);
        start = 1'b1;
        at    = cyc;
        @(negedge meg25);
        start = 1'b0;
    endtask

    task automatic pulse_start2();
        @(negedge meg25);
        start2 = 1'b1;
        @(negedge meg25);
        start2 = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int at);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge meg25);
            n++;
        end
        at = cyc;
        check("end_reached", done | error, 1);
    endtask

    task automatic wait_end2(input int budget);
        int n = 0;
        while (!(done2 || error2) && n < budget) begin
            @(negedge meg25);
            n++;
        end
        check("end2_reached", done2 | error2, 1);
    endtask

    initial begin
        int s, t;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge meg25);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_index", err_index, 0);
        check("rst_req", sif.req, 0);
        check("rst_addr", sif.addr, 0);
        rst = 1'b0;

        // Main table: write, 5 ms delay, end.
        nreq = 0;
        exp_q.push_back('{16'h3008, 8'h82});
        pulse_start(s);
        wait_end(400, t);
        check("a_first_req_lat", first_req - s, 3);
        check("a_done", done, 1);
        check("a_busy", busy, 0);
        check("a_error", error, 0);
        check("a_nreq", nreq, 1);
        check("a_sb_left", exp_q.size(), 0);
        check("a_delay_len", ((t - resp_cyc) >= 125) && ((t - resp_cyc) <= 135), 1);

        // Two NACKs then ACK.
        nreq = 0; nack_left = 2;
        repeat (3) exp_q.push_back('{16'h3008, 8'h82});
        pulse_start(s);
        check("b_done_clr", done, 0);
        check("b_busy", busy, 1);
        wait_end(500, t);
        check("b_done", done, 1);
        check("b_error", error, 0);
        check("b_nreq", nreq, 3);
        check("b_sb_left", exp_q.size(), 0);

        // Four NACKs exhaust the retries.
        nreq = 0; nack_left = 4;
        repeat (4) exp_q.push_back('{16'h3008, 8'h82});
        pulse_start(s);
        wait_end(600, t);
        check("c_error", error, 1);
        check("c_err_index", err_index, 0);
        check("c_busy", busy, 0);
        check("c_done", done, 0);
        repeat (40) @(negedge meg25);
        check("c_nreq", nreq, 4);
        check("c_sb_left", exp_q.size(), 0);

        // Engine never answers: timeout path.
        nreq = 0; mute = 1; nack_left = 0;
        repeat (4) exp_q.push_back('{16'h3008, 8'h82});
        pulse_start(s);
        check("d_err_clr", error, 0);
        wait_end(4 * (TO + 2) + 60, t);
        check("d_error", error, 1);
        check("d_req_spacing", last_req - prev_req, TO + 2);
        check("d_nreq", nreq, 4);
        check("d_total", ((t - s) >= 4 * TO) && ((t - s) <= 4 * TO + 20), 1);
        check("d_sb_left", exp_q.size(), 0);
        mute = 0;

        // Reset while the delay entry is counting, then restart.
        nreq = 0;
        exp_q.push_back('{16'h3008, 8'h82});
        pulse_start(s);
        repeat (38) @(negedge meg25);
        check("e_busy_in_delay", busy, 1);
        @(negedge meg25);
        rst = 1'b1;
        #1;
        check("e_rst_busy", busy, 0);
        check("e_rst_done", done, 0);
        check("e_rst_error", error, 0);
        check("e_rst_req", sif.req, 0);
        check("e_rst_addr", sif.addr, 0);
        check("e_nreq_before", nreq, 1);
        pend = 0;
        @(negedge meg25);
        rst  = 1'b0;
        nreq = 0;
        exp_q.push_back('{16'h3008, 8'h82});
        pulse_start(s);
        wait_end(400, t);
        check("e_first_req_lat", first_req - s, 3);
        check("e_done", done, 1);
        check("e_nreq", nreq, 1);
        check("e_sb_left", exp_q.size(), 0);

        // Illegal command at index 2, then rerun from ERROR.
        nreq2 = 0;
        exp2_q.push_back('{16'h3103, 8'h11});
        pulse_start2();
        wait_end2(100);
        check("f_error", error2, 1);
        check("f_err_index", err_index2, 2);
        check("f_busy", busy2, 0);
        check("f_done", done2, 0);
        check("f_nreq", nreq2, 1);
        exp2_q.push_back('{16'h3103, 8'h11});
        pulse_start2();
        check("f_err_clr", error2, 0);
        check("f_err_index_clr", err_index2, 0);
        wait_end2(100);
        check("f_error_again", error2, 1);
        check("f_err_index_again", err_index2, 2);
        check("f_nreq_again", nreq2, 2);
        check("f_sb_left", exp2_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
